// File: rtl/chip8_pixel_renderer_if.sv
// Framebuffer read port between the scanline renderer (master) and the
// dual-port framebuffer RAM (slave). Read data is valid the cycle after fb_rd.
interface chip8_pixel_renderer_if;
    logic [7:0] fb_addr;
    logic       fb_rd;
    logic [7:0] fb_data;

    modport master (output fb_addr, output fb_rd, input fb_data);
    modport slave  (input fb_addr, input fb_rd, output fb_data);
endinterface

// File: rtl/chip8_pixel_renderer.sv
// CHIP-8 64x32 scanline renderer: fetches one row per hblank, expands to 10x10 pixels.
// Define CHIP8_BORDER_EN to paint active lines below the image blue instead of black.
module chip8_pixel_renderer #(
    parameter logic [2:0] FG_COLOR = 3'b111,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    counter_x,
    input  logic [9:0]                    counter_y,
    input  logic [5:0]                    counter_x_10,
    input  logic                          in_display_area,
    input  logic                          vga_h_sync_in,
    input  logic                          vga_v_sync_in,
    chip8_pixel_renderer_if.master        fb,
    output logic                          vga_r,
    output logic                          vga_g,
    output logic                          vga_b,
    output logic                          vga_h_sync,
    output logic                          vga_v_sync
);

`ifdef CHIP8_BORDER_EN
    localparam logic [2:0] BORDER = 3'b001;
`else
    localparam logic [2:0] BORDER = 3'b000;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state;
    logic [5:0]      tgt_row, nxt_row;
    logic [3:0]      tgt_sub, nxt_sub;
    logic [2:0]      idx, cap_idx;
    logic            rd_q;
    logic [7:0][7:0] line_buf;
    logic            line_valid;
    logic            pix_bit;
    logic [2:0]      rgb_q, colour;
    logic            line_start;

    assign line_start = (counter_x == 10'd640);

    // Target line is the one after the current line; the last two sync lines re-arm row 0.
    always_comb begin
        nxt_row = tgt_row;
        nxt_sub = tgt_sub;
        if (counter_y == 10'd524 || counter_y == 10'd525) begin
            nxt_row = 6'd0;
            nxt_sub = 4'd0;
        end else if (tgt_sub == 4'd9) begin
            nxt_sub = 4'd0;
            nxt_row = tgt_row + 6'd1;
        end else begin
            nxt_sub = tgt_sub + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_row <= 6'd0;
            tgt_sub <= 4'd0;
        end else if (line_start) begin
            tgt_row <= nxt_row;
            tgt_sub <= nxt_sub;
        end
    end

    // Fetch: 8 read cycles, then one drain cycle so byte 7 lands before line_valid rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fb.fb_rd   <= 1'b0;
            fb.fb_addr <= 8'd0;
            idx        <= 3'd0;
            cap_idx    <= 3'd0;
            rd_q       <= 1'b0;
            line_buf   <= '0;
            line_valid <= 1'b0;
        end else begin
            rd_q    <= fb.fb_rd;
            cap_idx <= idx;
            if (rd_q)
                line_buf[cap_idx] <= fb.fb_data;
            case (state)
                IDLE: begin
                    if (line_start) begin
                        if (nxt_row < 6'd32) begin
                            state      <= FETCH;
                            fb.fb_rd   <= 1'b1;
                            fb.fb_addr <= {nxt_row[4:0], 3'd0};
                            idx        <= 3'd0;
                        end else begin
                            line_valid <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (idx == 3'd7) begin
                        fb.fb_rd <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        idx        <= idx + 3'd1;
                        fb.fb_addr <= {fb.fb_addr[7:3], idx + 3'd1};
                    end
                end
                DRAIN: begin
                    line_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 2 uses in_display_area directly: it already lags the counters by one clock.
    always_comb begin
        colour = 3'b000;
        if (in_display_area)
            colour = line_valid ? (pix_bit ? FG_COLOR : BG_COLOR) : BORDER;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_bit    <= 1'b0;
            rgb_q      <= 3'b000;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
        end else begin
            pix_bit    <= line_buf[counter_x_10[5:3]][3'd7 - counter_x_10[2:0]];
            rgb_q      <= colour;
            vga_h_sync <= vga_h_sync_in;
            vga_v_sync <= vga_v_sync_in;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_chip8_pixel_renderer.sv
// Directed bench for chip8_pixel_renderer: drives sync-generator counters line by line,
// models the framebuffer RAM, and checks colour, sync and fetch behaviour.
module tb_chip8_pixel_renderer;

`ifdef CHIP8_BORDER_EN
    localparam logic [2:0] BORDER_EXP = 3'b001;
`else
    localparam logic [2:0] BORDER_EXP = 3'b000;
`endif

    typedef struct {
        int         tag;
        int         y;
        int         x;
        logic [2:0] rgb;
    } vec_t;

    localparam int NV = 18;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] counter_x, counter_y;
    logic [5:0] counter_x_10;
    logic       in_display_area, vga_h_sync_in, vga_v_sync_in;
    logic       vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync;
    logic [7:0] mem [256];

    chip8_pixel_renderer_if fb();

    chip8_pixel_renderer dut (
        .clk             (clk),
        .reset           (reset),
        .counter_x       (counter_x),
        .counter_y       (counter_y),
        .counter_x_10    (counter_x_10),
        .in_display_area (in_display_area),
        .vga_h_sync_in   (vga_h_sync_in),
        .vga_v_sync_in   (vga_v_sync_in),
        .fb              (fb.master),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .vga_h_sync      (vga_h_sync),
        .vga_v_sync      (vga_v_sync)
    );

    always #5 clk = ~clk;

    // Synchronous-read framebuffer RAM
    always @(posedge clk) if (fb.fb_rd) fb.fb_data <= mem[fb.fb_addr];

    vec_t vec [NV];
    int   n_tests = 0, n_fail = 0;
    int   px1, py1, px2, py2, tg1, tg2, cur_tag;
    int   stepno, rd_cnt, first_addr, last_addr, first_step, last_step;
    int   contig, hs_err, blank_err;
    logic hs_hi, hs_lo;
    logic [2:0] o_rgb;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample outputs (they belong to counters applied two steps ago), then drive.
    task automatic step(input int x, input int y);
        @(negedge clk);
        stepno++;
        o_rgb = {vga_r, vga_g, vga_b};
        if (fb.fb_rd) begin
            if (rd_cnt == 0) begin
                first_addr = int'(fb.fb_addr);
                first_step = stepno;
            end else if (int'(fb.fb_addr) != last_addr + 1) begin
                contig = 0;
            end
            last_addr = int'(fb.fb_addr);
            last_step = stepno;
            rd_cnt++;
        end
        if (vga_h_sync !== vga_h_sync_in) hs_err++;
        if (tg2 != 0 && px2 >= 640 && o_rgb != 3'b000) blank_err++;
        if (tg2 == 1 && px2 == 655) hs_hi = vga_h_sync;
        if (tg2 == 1 && px2 == 656) hs_lo = vga_h_sync;
        for (int i = 0; i < NV; i++)
            if (vec[i].tag == tg2 && vec[i].y == py2 && vec[i].x == px2)
                check($sformatf("rgb_t%0d_y%0d_x%0d", tg2, py2, px2), int'(o_rgb), int'(vec[i].rgb));
        in_display_area = (px1 < 640 && py1 < 480);
        vga_h_sync_in   = !(px1 >= 656 && px1 < 752);
        vga_v_sync_in   = !(py1 == 490 || py1 == 491);
        counter_x       = 10'(x);
        counter_y       = 10'(y);
        counter_x_10    = 6'(x / 10);
        px2 = px1; py2 = py1; tg2 = tg1;
        px1 = x;   py1 = y;   tg1 = cur_tag;
    endtask

    task automatic run_line(input int y, input int x0, input int x1, input int tag);
        cur_tag = tag;
        rd_cnt  = 0;
        contig  = 1;
        for (int x = x0; x <= x1; x++) step(x, y);
    endtask

    task automatic fetch_check(input string name, input int base);
        check({name, "_cnt"}, rd_cnt, 8);
        check({name, "_base"}, first_addr, base);
        check({name, "_contig"}, int'(contig == 1 && (last_step - first_step) == 7), 1);
    endtask

    initial begin
        vec[0]  = '{1, 0, 0, 3'b111};
        vec[1]  = '{1, 0, 9, 3'b111};
        vec[2]  = '{1, 0, 10, 3'b000};
        vec[3]  = '{1, 0, 639, 3'b000};
        vec[4]  = '{2, 10, 0, 3'b000};
        vec[5]  = '{2, 10, 629, 3'b000};
        vec[6]  = '{2, 10, 630, 3'b111};
        vec[7]  = '{2, 10, 639, 3'b111};
        vec[8]  = '{3, 319, 240, 3'b111};
        vec[9]  = '{3, 319, 250, 3'b000};
        vec[10] = '{3, 319, 260, 3'b111};
        vec[11] = '{3, 319, 319, 3'b111};
        vec[12] = '{3, 319, 320, 3'b000};
        vec[13] = '{4, 320, 0, BORDER_EXP};
        vec[14] = '{4, 320, 639, BORDER_EXP};
        vec[15] = '{4, 320, 700, 3'b000};
        vec[16] = '{5, 0, 5, 3'b111};
        vec[17] = '{5, 0, 15, 3'b000};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]   = 8'h80;   // row 0: leftmost pixel only
        mem[15]  = 8'h01;   // row 1: rightmost pixel only
        mem[251] = 8'hA5;   // row 31, byte 3

        reset = 1'b0;
        counter_x = '0; counter_y = '0; counter_x_10 = '0;
        in_display_area = 1'b0; vga_h_sync_in = 1'b1; vga_v_sync_in = 1'b1;
        px1 = 700; py1 = 500; px2 = 700; py2 = 500; tg1 = 0; tg2 = 0; cur_tag = 0;
        stepno = 0; rd_cnt = 0; contig = 1; hs_err = 0; blank_err = 0;
        first_addr = -1; last_addr = -1; first_step = 0; last_step = 0;
        hs_hi = 1'b0; hs_lo = 1'b1;

        #12;
        check("rst_fb_rd", int'(fb.fb_rd), 0);
        check("rst_fb_addr", int'(fb.fb_addr), 0);
        check("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("rst_hsync", int'(vga_h_sync), 1);
        check("rst_vsync", int'(vga_v_sync), 1);
        @(negedge clk);
        reset = 1'b1;

        run_line(523, 630, 669, 0);
        fetch_check("fetch_y523", 0);
        run_line(524, 630, 669, 0);
        fetch_check("fetch_y524", 0);
        run_line(525, 630, 669, 0);
        fetch_check("fetch_y525", 0);
        run_line(0, 0, 799, 1);
        for (int y = 1; y <= 8; y++) run_line(y, 630, 669, 0);
        run_line(9, 630, 669, 0);
        fetch_check("fetch_y9", 8);
        run_line(10, 0, 799, 2);
        for (int y = 11; y <= 318; y++) run_line(y, 630, 669, 0);
        fetch_check("fetch_y318", 248);
        run_line(319, 0, 799, 3);
        check("no_fetch_y319", rd_cnt, 0);
        run_line(320, 0, 799, 4);
        check("no_fetch_y320", rd_cnt, 0);

        // Reset in the middle of a row-0 fetch
        run_line(524, 630, 643, 0);
        check("midfetch_rd_before", int'(fb.fb_rd), 1);
        #2 reset = 1'b0;
        #1;
        check("midfetch_rst_rd", int'(fb.fb_rd), 0);
        check("midfetch_rst_addr", int'(fb.fb_addr), 0);
        check("midfetch_rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("midfetch_rst_hsync", int'(vga_h_sync), 1);
        check("midfetch_rst_vsync", int'(vga_v_sync), 1);
        @(negedge clk);
        reset = 1'b1;
        run_line(524, 645, 669, 0);
        check("midfetch_no_resume", rd_cnt, 0);
        run_line(525, 630, 669, 0);
        fetch_check("refetch_y525", 0);
        run_line(0, 0, 799, 5);

        check("blank_rgb_zero", blank_err, 0);
        check("hsync_lag_1clk", hs_err, 0);
        check("hsync_hi_x655", int'(hs_hi), 1);
        check("hsync_lo_x656", int'(hs_lo), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
